// File: rtl/display_message_driver_pkg.sv
// display_pkg: message codes, panel character set and the text lookup used by
// the front-panel 7-segment message driver.
package display_pkg;

  typedef enum logic [3:0] {
    MSG_IDLE = 4'd0,
    MSG_CE01 = 4'd1,
    MSG_CL02 = 4'd2,
    MSG_CC05 = 4'd3,
    MSG_CP10 = 4'd4,
    MSG_ERSR = 4'd5,
    MSG_ERSP = 4'd6,
    MSG_ERSN = 4'd7,
    MSG_ERDI = 4'd8
  } msg_code_t;

  typedef enum logic [3:0] {
    CH_C, CH_E, CH_L, CH_P, CH_R, CH_S, CH_N, CH_D,
    CH_0, CH_1, CH_2, CH_5, CH_BLANK
  } char_t;

  // Every message is four characters, left-aligned on the panel.
  localparam int unsigned TEXT_LEN = 4;

  // Raw controller codes outside the defined set fall back to IDLE.
  function automatic msg_code_t to_msg_code(input logic [3:0] raw);
    msg_code_t code;
    case (raw)
      4'd1:    code = MSG_CE01;
      4'd2:    code = MSG_CL02;
      4'd3:    code = MSG_CC05;
      4'd4:    code = MSG_CP10;
      4'd5:    code = MSG_ERSR;
      4'd6:    code = MSG_ERSP;
      4'd7:    code = MSG_ERSN;
      4'd8:    code = MSG_ERDI;
      default: code = MSG_IDLE;
    endcase
    return code;
  endfunction

  function automatic logic is_error(input msg_code_t code);
    return code inside {MSG_ERSR, MSG_ERSP, MSG_ERSN, MSG_ERDI};
  endfunction

  // IDLE lights only the decimal points of the four text positions.
  function automatic logic idle_dot(input msg_code_t code, input int unsigned idx);
    return (code == MSG_IDLE) && (idx < TEXT_LEN);
  endfunction

  // Character shown at digit position idx; the letter I is drawn as a 1.
  function automatic char_t msg_char(input msg_code_t code, input int unsigned idx);
    char_t t0, t1, t2, t3, ch;
    t0 = CH_BLANK;
    t1 = CH_BLANK;
    t2 = CH_BLANK;
    t3 = CH_BLANK;
    case (code)
      MSG_CE01: begin t0 = CH_C; t1 = CH_E; t2 = CH_0; t3 = CH_1; end
      MSG_CL02: begin t0 = CH_C; t1 = CH_L; t2 = CH_0; t3 = CH_2; end
      MSG_CC05: begin t0 = CH_C; t1 = CH_C; t2 = CH_0; t3 = CH_5; end
      MSG_CP10: begin t0 = CH_C; t1 = CH_P; t2 = CH_1; t3 = CH_0; end
      MSG_ERSR: begin t0 = CH_E; t1 = CH_R; t2 = CH_S; t3 = CH_R; end
      MSG_ERSP: begin t0 = CH_E; t1 = CH_R; t2 = CH_S; t3 = CH_P; end
      MSG_ERSN: begin t0 = CH_E; t1 = CH_R; t2 = CH_S; t3 = CH_N; end
      MSG_ERDI: begin t0 = CH_E; t1 = CH_R; t2 = CH_D; t3 = CH_1; end
      default:  ;
    endcase
    case (idx)
      0:       ch = t0;
      1:       ch = t1;
      2:       ch = t2;
      3:       ch = t3;
      default: ch = CH_BLANK;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/display_message_driver_char_to_seg.sv
// char_to_seg: combinational character to active-low segment pattern,
// bit 6 = a ... bit 0 = g.
module char_to_seg
  import display_pkg::*;
(
  input  char_t      i_char,
  output logic [6:0] o_seg_n
);

  // Segment decode; anything unknown stays dark.
  always_comb begin
    o_seg_n = 7'b1111111;
    case (i_char)
      CH_0:     o_seg_n = 7'b0000001;
      CH_1:     o_seg_n = 7'b1001111;
      CH_2:     o_seg_n = 7'b0010010;
      CH_5:     o_seg_n = 7'b0100100;
      CH_C:     o_seg_n = 7'b0110001;
      CH_E:     o_seg_n = 7'b0110000;
      CH_L:     o_seg_n = 7'b1110001;
      CH_P:     o_seg_n = 7'b0011000;
      CH_R:     o_seg_n = 7'b1111010;
      CH_S:     o_seg_n = 7'b0100100;
      CH_N:     o_seg_n = 7'b1101010;
      CH_D:     o_seg_n = 7'b1000010;
      CH_BLANK: o_seg_n = 7'b1111111;
      default:  o_seg_n = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/display_message_driver.sv
// display_message_driver: time-multiplexed 7-segment message driver with a
// minimum hold time, valid/ready handshake, error preemption and error blink.
module display_message_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int HOLD_FRAMES  = 200,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  msg_valid,
  input  logic [3:0]            msg_code,
  output logic                  msg_ready,
  input  logic                  dp_in,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] dig
);

  if (NUM_DIGITS < 4) begin : g_bad_num_digits
    $error("display_message_driver: NUM_DIGITS must be >= 4");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("display_message_driver: PRESCALE must be >= 1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("display_message_driver: BLINK_FRAMES must be >= 1");
  end

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam int HW = $clog2(HOLD_FRAMES) + 1;
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  localparam int DW = $clog2(NUM_DIGITS);

  logic [PW-1:0]         r_presc;
  logic [DW-1:0]         r_digit;
  logic [HW-1:0]         r_hold;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_blink_on;
  msg_code_t             r_cur_code;
  logic [6:0]            r_seg_n;
  logic                  r_dp_n;
  logic [NUM_DIGITS-1:0] r_dig;

  logic [DW-1:0] w_next_digit;
  logic          w_tick;
  logic          w_frame_end;
  msg_code_t     w_in_code;
  logic          w_accept;
  logic          w_blink_flip;
  logic          w_blink_vis;
  char_t         w_char;
  logic [6:0]    w_seg_pat;
  logic          w_idle_dot;

  assign w_tick       = (r_presc == PW'(PRESCALE - 1));
  assign w_next_digit = (r_digit == DW'(NUM_DIGITS - 1)) ? '0 : r_digit + DW'(1);
  assign w_frame_end  = w_tick && (r_digit == DW'(NUM_DIGITS - 1));

  assign msg_ready = (r_hold == '0);
  assign w_in_code = to_msg_code(msg_code);
  // Errors preempt a running hold; re-offering the shown code changes nothing.
  assign w_accept  = msg_valid && (w_in_code != r_cur_code) &&
                     (is_error(w_in_code) || msg_ready);

  // The render at a frame-end tick uses the post-toggle phase, so every digit
  // of one frame shares the same blink phase.
  assign w_blink_flip = w_frame_end && is_error(r_cur_code) &&
                        (r_blink_cnt == BW'(BLINK_FRAMES - 1));
  assign w_blink_vis  = r_blink_on ^ w_blink_flip;

  assign w_char     = msg_char(r_cur_code, 32'(w_next_digit));
  assign w_idle_dot = idle_dot(r_cur_code, 32'(w_next_digit));

  char_to_seg u_char_to_seg (
    .i_char  (w_char),
    .o_seg_n (w_seg_pat)
  );

  // Prescaler and scan position; the first tick after reset selects digit 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc <= '0;
      r_digit <= DW'(NUM_DIGITS - 1);
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_digit <= w_next_digit;
    end
  end

  // Message state: accept loads a fresh hold and blink phase and wins over a
  // coincident frame end.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cur_code  <= MSG_IDLE;
      r_hold      <= '0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_accept) begin
      r_cur_code  <= w_in_code;
      r_hold      <= HW'(HOLD_FRAMES);
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_frame_end) begin
      if (r_hold != '0) r_hold <= r_hold - HW'(1);
      if (is_error(r_cur_code)) begin
        if (w_blink_flip) begin
          r_blink_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  // Segments, dot and digit enable change together on each tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_seg_n <= 7'h7F;
      r_dp_n  <= 1'b1;
      r_dig   <= '0;
    end else if (w_tick) begin
      r_dig <= NUM_DIGITS'(1) << w_next_digit;
      if (w_blink_vis) begin
        r_seg_n <= w_seg_pat;
        r_dp_n  <= ~(dp_in | w_idle_dot);
      end else begin
        r_seg_n <= 7'h7F;
        r_dp_n  <= ~dp_in;
      end
    end
  end

  assign seg_n = r_seg_n;
  assign dp_n  = r_dp_n;
  assign dig   = r_dig;

endmodule

// File: doc/display_message_driver.md
# display_message_driver

Parametrised, time-multiplexed 7-segment message driver for the coffee-machine front panel. It accepts a message code from the controller FSM and holds it for a minimum display time, with a valid/ready handshake and preemption by error codes. Error messages blink. The block scans NUM_DIGITS common-anode digits with active-low segments and sits between the main controller and the panel pins.

## Interface
Parameters:
- NUM_DIGITS, 4: digits scanned; must be ≥ 4 (elaboration error otherwise).
- PRESCALE, 50000: CLK cycles per digit tick; must be ≥ 1.
- HOLD_FRAMES, 200: minimum frames a non-error message stays before msg_ready returns.
- BLINK_FRAMES, 100: frames per blink half-period for error messages.

Ports:
- CLK  in  1: system clock; single clock domain.
- RST  in  1: synchronous, active-high reset.
- msg_valid  in  1: msg_code is offered this cycle.
- msg_code  in  4: message code (see Operation).
- msg_ready  out  1: a non-error code will be accepted this cycle.
- dp_in  in  1: external decimal-point request; applies to all digits.
- seg_n  out  7: segments, active low; bit 6 = a … bit 0 = g.
- dp_n  out  1: decimal point, active low.
- dig  out  NUM_DIGITS: digit enables, active high, one-hot; dig[0] is the leftmost digit.

## Operation
- Codes: 0 IDLE "....", 1 CE01, 2 CL02, 3 CC05, 4 CP10, 5 ERSR, 6 ERSP, 7 ERSN, 8 ERDI. Codes 9–15 map to IDLE.
- Codes 5–8 are error codes.
- Text is left-aligned. Digit positions ≥ 4 show blank.
- IDLE shows blank segments with the dp lit on digits 0–3.
- State: cur_code, hold_cnt, blink_cnt, blink_on, prescaler, digit index.
- Acceptance rules:
  - A non-error code is accepted when msg_valid && msg_ready.
  - An error code is accepted whenever msg_valid, regardless of msg_ready (preemption).
  - A code equal to cur_code is dropped with no state change.
- On accept:
  - cur_code updates next cycle.
  - hold_cnt loads HOLD_FRAMES.
  - blink_cnt is cleared and blink_on is set to 1.
- msg_ready = (hold_cnt == 0). It is combinational from registered state.
- hold_cnt decrements by 1 at each frame end and saturates at 0.
- Blinking: for error codes, blink_on toggles every BLINK_FRAMES frames. While blink_on=0, seg_n is all 1s and dp_n reflects dp_in only. Non-error codes never blink.
- dp_n = ~(dp_in | idle_dot).

## Timing
- Reset values:
  - seg_n = 7'h7F, dp_n = 1, dig = 0.
  - msg_ready = 1, cur_code = IDLE.
  - hold_cnt = 0, blink_cnt = 0, blink_on = 1.
  - prescaler = 0, digit index = NUM_DIGITS-1, so the first tick selects digit 0.
- Digit tick:
  - Asserted when the prescaler reaches PRESCALE-1; the prescaler then wraps to 0.
  - On a tick, the digit index advances modulo NUM_DIGITS.
  - A frame ends on the tick that selects digit 0 again.
- Outputs seg_n, dp_n and dig are registered. They all update together in the cycle after a tick, so a digit never shows another digit's segments.
- Latency: a code accepted in cycle t is reflected from the first output update after tick t+1 or later. The current digit is not re-rendered early.
- RST mid-scan or mid-hold returns every register to its reset value on the next edge. The handshake is not preserved across reset.
- A simultaneous frame end and accept: the accept wins. hold_cnt loads HOLD_FRAMES and is not decremented that cycle.
- The counter widths are $clog2 of their parameter plus 1, with no overflow.

## Structure
- display_pkg holds:
  - the msg_code_t enum (the codes above);
  - the char_t enum (C, E, L, P, r, S, n, d, 0, 1, 2, 5, BLANK);
  - function msg_char(msg_code_t, index) returning char_t.
- Sub-module char_to_seg is combinational: char_t in, active-low 7-bit pattern out. Example patterns:
  - '0' = 7'b0000001
  - '1' = 7'b1001111
  - 'C' = 7'b0110001
  - 'E' = 7'b0110000
  - BLANK = 7'b1111111
- The top module contains the prescaler, scan counter, hold/blink counters, handshake and output registers.

## Test plan
Parameters NUM_DIGITS=4, PRESCALE=2, HOLD_FRAMES=2, BLINK_FRAMES=1.
- Reset, then idle for 16 cycles: dig cycles 0001→0010→0100→1000 every 2 cycles; seg_n stays 7F and dp_n=0 on each digit.
- msg_valid with code 1, ready=1: within one frame, digit 0 shows seg_n=0110001 and digit 3 shows 1001111; msg_ready=0 for 2 frames, then 1.
- Code 2 offered during hold: not accepted while msg_ready=0; accepted on the cycle ready rises; display shows CL02.
- Code 1 on display, code 5 offered mid-hold: accepted immediately; digit 0 shows 'E' (0110000); blinking alternates one frame lit and one frame seg_n=7F.
- Code 5 offered again while ERSR is displayed: no change to hold_cnt or blink phase. Then code 12: IDLE is displayed.
- Assert RST mid-frame while ERSR is blinking: the next cycle shows all reset values, and scanning restarts at digit 0 after 2 cycles.
